// File: rtl/io_write_client.sv
// Write-side client for one I/O arbiter slot: buffers (address, data) write requests
// in a small FIFO and presents them one at a time, holding each until acknowledged.
module io_write_client #(
  parameter int WORD_SIZE   = 16,  // system word size (gc::WORD_SIZE)
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wrValid,
  output logic                          wrReady,
  input  logic [WORD_SIZE-1:0]          wrAddr,
  input  logic [WORD_SIZE-1:0]          wrData,
  output logic [WORD_SIZE-1:0]          addressIn,
  output logic [WORD_SIZE-1:0]          dataIn,
  output logic                          ioReq,
  output logic                          ioDir,
  input  logic                          dataValid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          timeoutErr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [WORD_SIZE-1:0]   address_in_q, address_in_d;
  logic [WORD_SIZE-1:0]   data_in_q, data_in_d;
  logic                   io_req_q, io_req_d;
  logic                   io_dir_q, io_dir_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [2*WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;

  // Ready depends only on the registered count, so a pop never frees a slot the same edge.
  assign wrReady = (count_q < CNT_W'(FIFO_DEPTH));
  assign push    = wrValid && wrReady;

  always_comb begin
    // NOTE: every signal gets a default here first; a path that leaves one unassigned infers a latch.
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    address_in_d  = address_in_q;
    data_in_d     = data_in_q;
    io_req_d      = io_req_q;
    io_dir_d      = io_dir_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (count_q != '0) begin
          {address_in_d, data_in_d} = mem_q[rd_ptr_q];
          io_req_d  = 1'b1;
          io_dir_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dataValid) begin
          pop      = 1'b1;
          io_req_d = 1'b0;
          io_dir_d = 1'b0;
          state_d  = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          pop           = 1'b1;
          timeout_err_d = 1'b1;
          io_req_d      = 1'b0;
          io_dir_d      = 1'b0;
          state_d       = GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tmo_cnt_q     <= '0;
      address_in_q  <= '0;
      data_in_q     <= '0;
      io_req_q      <= 1'b0;
      io_dir_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tmo_cnt_q     <= tmo_cnt_d;
      address_in_q  <= address_in_d;
      data_in_q     <= data_in_d;
      io_req_q      <= io_req_d;
      io_dir_q      <= io_dir_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wrAddr, wrData};
  end

  assign addressIn  = address_in_q;
  assign dataIn     = data_in_q;
  assign ioReq      = io_req_q;
  assign ioDir      = io_dir_q;
  assign count      = count_q;
  assign busy       = (count_q != '0);
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_io_write_client.sv
// Directed bench for io_write_client: single write, burst/backpressure, push on pop,
// timeout vs. last-edge ack, stray acks and reset during a pending request.
module tb_io_write_client;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wrValid;
  logic         wrReady;
  logic [W-1:0] wrAddr;
  logic [W-1:0] wrData;
  logic [W-1:0] addressIn;
  logic [W-1:0] dataIn;
  logic         ioReq;
  logic         ioDir;
  logic         dataValid;
  logic [2:0]   count;
  logic         busy;
  logic         timeoutErr;

  int checks   = 0;
  int failures = 0;

  io_write_client #(.WORD_SIZE(W), .FIFO_DEPTH(D), .ACK_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .addressIn  (addressIn),
    .dataIn     (dataIn),
    .ioReq      (ioReq),
    .ioDir      (ioDir),
    .dataValid  (dataValid),
    .count      (count),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wrValid = 1'b0; dataValid = 1'b0; wrAddr = '0; wrData = '0;
    step(); step();
    rst = 1'b0;
    check("rst_ioReq", ioReq, 0);
    check("rst_ioDir", ioDir, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    check("rst_wrReady", wrReady, 1);
    check("rst_addressIn", addressIn, 0);
    check("rst_dataIn", dataIn, 0);

    // Single write
    wrValid = 1'b1; wrAddr = 16'h0010; wrData = 16'hBEEF;
    step();
    wrValid = 1'b0;
    check("t1_count_after_push", count, 1);
    check("t1_ioReq_not_yet", ioReq, 0);
    step();
    check("t1_ioReq", ioReq, 1);
    check("t1_addressIn", addressIn, 16'h0010);
    check("t1_dataIn", dataIn, 16'hBEEF);
    check("t1_ioDir", ioDir, 1);
    step(); step();
    check("t1_hold_addr", addressIn, 16'h0010);
    dataValid = 1'b1;
    step();
    dataValid = 1'b0;
    check("t1_ioReq_done", ioReq, 0);
    check("t1_ioDir_done", ioDir, 0);
    check("t1_count_done", count, 0);
    check("t1_busy_done", busy, 0);

    // Burst of five with backpressure
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1; wrAddr = 16'h0100 + 16'(i); wrData = 16'hD000 + 16'(i);
      step();
    end
    check("t2_count_full", count, 4);
    check("t2_wrReady_full", wrReady, 0);
    check("t2_first_issued", addressIn, 16'h0100);
    check("t2_first_ioReq", ioReq, 1);
    wrAddr = 16'h0104; wrData = 16'hD004;
    step();
    check("t2_fifth_refused", count, 4);
    check("t2_wrReady_still0", wrReady, 0);

    // Push attempted on the same edge as a pop while full
    dataValid = 1'b1;
    step();
    dataValid = 1'b0;
    check("t3_push_refused_count", count, 3);
    check("t3_ioReq_gap", ioReq, 0);
    check("t3_wrReady_freed", wrReady, 1);
    step();
    wrValid = 1'b0;
    check("t3_push_accepted_count", count, 4);
    check("t3_next_issued", ioReq, 1);

    for (int i = 1; i <= 4; i++) begin
      check("t2_order_addr", addressIn, 16'h0100 + 16'(i));
      check("t2_order_data", dataIn, 16'hD000 + 16'(i));
      check("t2_order_ioReq", ioReq, 1);
      dataValid = 1'b1;
      step();
      dataValid = 1'b0;
      check("t2_ack_ioReq_low", ioReq, 0);
      check("t2_ack_count", count, 32'(4 - i));
      step();
      check("t2_gap_then_issue", ioReq, (i < 4) ? 1 : 0);
    end
    check("t2_busy_end", busy, 0);

    // Ack on the final timeout edge wins; then a genuine timeout drop
    wrValid = 1'b1; wrAddr = 16'h0200; wrData = 16'hA000;
    step();
    wrAddr = 16'h0201; wrData = 16'hA001;
    step();
    wrValid = 1'b0;
    check("t4_b0_issued", addressIn, 16'h0200);
    check("t4_b0_count", count, 2);
    repeat (TMO - 1) begin
      step();
      check("t4_b0_waiting", ioReq, 1);
    end
    dataValid = 1'b1;
    step();
    dataValid = 1'b0;
    check("t4_lastedge_ack_ioReq", ioReq, 0);
    check("t4_lastedge_ack_noerr", timeoutErr, 0);
    check("t4_lastedge_ack_count", count, 1);
    wrValid = 1'b1; wrAddr = 16'h0202; wrData = 16'hA002;
    step();
    wrValid = 1'b0;
    check("t4_b1_issued", addressIn, 16'h0201);
    check("t4_b1_ioReq", ioReq, 1);
    check("t4_b1_count", count, 2);
    repeat (TMO - 1) begin
      step();
      check("t4_b1_waiting", ioReq, 1);
      check("t4_b1_noerr_yet", timeoutErr, 0);
    end
    step();
    check("t4_drop_ioReq", ioReq, 0);
    check("t4_drop_err", timeoutErr, 1);
    check("t4_drop_count", count, 1);
    step();
    check("t4_b2_issued", ioReq, 1);
    check("t4_b2_addr", addressIn, 16'h0202);
    check("t4_b2_data", dataIn, 16'hA002);
    dataValid = 1'b1;
    step();
    check("t4_b2_done_count", count, 0);
    check("t4_err_sticky", timeoutErr, 1);

    // Stray acks in GAP and IDLE (dataValid still high)
    step();
    check("t6_gap_ack_count", count, 0);
    check("t6_gap_ack_ioReq", ioReq, 0);
    step();
    check("t6_idle_ack_ioReq", ioReq, 0);
    wrValid = 1'b1; wrAddr = 16'h0300; wrData = 16'hC000;
    step();
    wrValid = 1'b0;
    check("t6_push_with_ack_count", count, 1);
    step();
    dataValid = 1'b0;
    check("t6_idle_ack_no_pop", count, 1);
    check("t6_issue_ioReq", ioReq, 1);
    check("t6_issue_addr", addressIn, 16'h0300);

    // Reset while a request is pending with three entries buffered
    wrValid = 1'b1; wrAddr = 16'h0301; wrData = 16'hC001;
    step();
    wrAddr = 16'h0302; wrData = 16'hC002;
    step();
    wrValid = 1'b0;
    check("t5_pre_count", count, 3);
    check("t5_pre_ioReq", ioReq, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ioReq", ioReq, 0);
    check("t5_count", count, 0);
    check("t5_timeoutErr", timeoutErr, 0);
    check("t5_wrReady", wrReady, 1);
    check("t5_addressIn", addressIn, 0);
    repeat (4) begin
      step();
      check("t5_no_issue", ioReq, 0);
      check("t5_count_stays0", count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_write_client.md
Name: io_write_client

Overview:
- Write-side client for one per-device slot of the I/O arbiter; the complement of the read-only VGA client.
- A local producer pushes (address, data) write requests through a valid/ready port.
- The block buffers them in a small FIFO and presents them one at a time to the arbiter slot with a request/direction flag.
- It holds each request stable until the arbiter acknowledges it on the slot's data-valid strobe, then retires it.

Parameters:
- WORD_SIZE, gc::WORD_SIZE, width of address and data words.
- FIFO_DEPTH, 4, request buffer entries; power of two, at least 2.
- ACK_TIMEOUT, 255, cycles to wait for an acknowledge before dropping the request; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wrValid  in  1  producer has a request.
- wrReady  out  1  FIFO can accept a request.
- wrAddr  in  WORD_SIZE  target I/O address.
- wrData  in  WORD_SIZE  word to write.
- addressIn  out  WORD_SIZE  address to arbiter slot (addressInArr entry).
- dataIn  out  WORD_SIZE  write data to arbiter slot (dataInArr entry).
- ioReq  out  1  request pending to arbiter.
- ioDir  out  1  transfer direction; constant 1 (write) whenever ioReq=1.
- dataValid  in  1  arbiter acknowledge strobe (dataValidArr entry).
- count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered, including the in-flight one.
- busy  out  1  high when count != 0.
- timeoutErr  out  1  sticky; set when a request is dropped on timeout.

Behaviour:
- **Clocking and reset:** one clock domain, all state updates on rising clk. rst is synchronous, active-high.
- **Reset values:**
  - Outputs: ioReq=0, ioDir=0, addressIn=0, dataIn=0, count=0, busy=0, timeoutErr=0. wrReady is 1 after reset.
  - Internal: FIFO pointers cleared; FSM in IDLE.
  - An in-flight request is abandoned with no further strobe.
- **FIFO:**
  - Push when wrValid && wrReady at a clock edge.
  - wrReady = (count < FIFO_DEPTH), combinational from registered count only.
  - No same-cycle bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- **FSM states:** IDLE, REQ, GAP.
  - **IDLE:** if count != 0, load the head entry into addressIn/dataIn, set ioReq=1, ioDir=1, clear the timeout counter, go to REQ. dataValid is ignored.
  - **REQ:**
    - addressIn, dataIn and ioReq are held stable.
    - On dataValid=1: pop the head, ioReq=0 and ioDir=0 after this edge, go to GAP.
    - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT-1 without an acknowledge: pop (drop) the head, set timeoutErr, ioReq=0, go to GAP.
    - An acknowledge on the same edge as the timeout wins: the request counts as completed and timeoutErr is not set.
  - **GAP:** ioReq stays low for exactly this one cycle, then behaves as IDLE (loads the next entry if count != 0). dataValid is ignored.
- **Latency:**
  - A push accepted into an empty FIFO at edge k gives count=1 after k and ioReq=1 after edge k+1.
  - Back-to-back requests are separated by exactly one ioReq-low cycle.
- **Stability and flags:**
  - addressIn/dataIn change only on the edge that asserts ioReq.
  - timeoutErr clears only on rst.

Test Plan:
1. **Single write:** after reset, push addr=0x0010, data=0xBEEF (FIFO empty).
   - Required: ioReq=1 with addressIn=0x0010, dataIn=0xBEEF, ioDir=1 two edges after the push.
   - Pulse dataValid 3 cycles later. Required: ioReq=0 next cycle; count=0; busy=0.
2. **Burst and backpressure:** push 5 requests on consecutive cycles with dataValid held low.
   - Required: requests 1–4 accepted; wrReady=0 after the 4th; 5th held.
   - Ack each request. Required: requests issued in FIFO order with one-cycle ioReq gaps; 5th accepted once count<4.
3. **Push on pop while full:** FIFO full, assert wrValid on the same edge as dataValid.
   - Required: push refused that edge; count=3 after; push accepted next edge.
4. **Timeout:** request pending, no ack for ACK_TIMEOUT cycles.
   - Required: entry dropped, timeoutErr=1 and stays 1.
   - The next entry is issued after one gap cycle. An ack on the final timeout edge instead leaves timeoutErr=0.
5. **Reset mid-request:** rst during REQ with 3 entries buffered.
   - Required: next cycle ioReq=0, count=0, timeoutErr=0, wrReady=1; no request issued afterwards.
6. **Stray ack:** pulse dataValid in IDLE and in GAP.
   - Required: no pop; count unchanged; no spurious issue.
